change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter COIN_VAL_0, default 100, smallest coin value.
REQ-002 SHALL have parameter COIN_VAL_1, default 500, middle coin value.
REQ-003 SHALL have parameter COIN_VAL_2, default 1000, largest coin value (COIN_VAL_2 > COIN_VAL_1 > COIN_VAL_0 > 0).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_start  input  1  request to return change; sampled in IDLE only.
REQ-007 SHALL have port current_total  input  `kTotalBits  balance from the state register, latched on accepted i_start.
REQ-008 SHALL have port i_coin_ready  input  1  coin ejector accepts the presented coin.
REQ-009 SHALL have port o_coin_valid  output  1  a coin is presented.
REQ-010 SHALL have port o_coin_type  output  3  one-hot coin select: bit0 COIN_VAL_0, bit1 COIN_VAL_1, bit2 COIN_VAL_2.
REQ-011 SHALL have port o_busy  output  1  high from the cycle after accepted i_start through the DONE cycle.
REQ-012 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port o_residual  output  `kTotalBits  undispensable remainder, valid from o_done until the next accepted i_start.

Function
REQ-014 SHALL implement FSM states IDLE, DISPENSE, DONE, all registered.
REQ-015 SHALL accept i_start only in IDLE: latch current_total into the remaining register and go to DISPENSE next cycle; i_start in DISPENSE/DONE ignored.
REQ-016 SHALL, in DISPENSE, present the largest coin with value <= remaining; o_coin_valid high, o_coin_type one-hot, both registered.
REQ-017 SHALL hold o_coin_valid and o_coin_type stable until a cycle with o_coin_valid && i_coin_ready.
REQ-018 SHALL, on handshake, subtract the coin value from remaining; the next coin is presented the following cycle (max throughput one coin per 2 cycles).
REQ-019 SHALL go to DONE with o_coin_valid low when remaining < COIN_VAL_0, including a latched amount of 0 (zero coins presented).
REQ-020 SHALL, in DONE, pulse o_done for exactly one cycle, copy remaining to o_residual, then return to IDLE.
REQ-021 SHALL use `kTotalBits-wide unsigned arithmetic; subtraction never underflows because selection guarantees coin <= remaining.
REQ-022 SHALL ignore i_coin_ready while o_coin_valid is low.
REQ-023 SHALL ignore current_total changes after latching.

Reset
REQ-024 SHALL, on rising clk with reset_n low, force state IDLE, remaining 0, o_coin_valid 0, o_coin_type 0, o_busy 0, o_done 0, o_residual 0, count 0.
REQ-025 SHALL abort any dispense on reset mid-operation: no o_done pulse and no further coin presented.
REQ-026 SHALL take reset over i_start and i_coin_ready in the same cycle.

Configuration
REQ-027 SHALL, with CHANGE_COUNT_EN defined, add output o_coin_count (8 bits): cleared on accepted i_start, incremented on each handshake, saturating at 255, held after o_done.
REQ-028 SHALL, without CHANGE_COUNT_EN, omit the o_coin_count port and its counter logic entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover current_total=1600, i_coin_ready always 1 -> coins 1000,500,100 in order, o_done once, o_residual=0, o_coin_count=3 if enabled.
REQ-030 SHALL cover current_total=250 -> two 100 coins, o_residual=50.
REQ-031 SHALL cover current_total=0 -> no o_coin_valid, o_done one cycle after entering DISPENSE, o_residual=0.
REQ-032 SHALL cover current_total=500 with i_coin_ready held low 5 cycles -> o_coin_valid and type 3'b010 stable all 5 cycles; one coin on release.
REQ-033 SHALL cover i_start re-asserted and current_total changed mid-dispense of 2000 -> ignored; exactly two 1000 coins.
REQ-034 SHALL cover reset_n low after the first coin of 1500 -> all outputs 0 next cycle, no o_done, IDLE accepts a new i_start.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: returns a latched balance as a sequence of coins.
// It always presents the largest coin that still fits, one coin at a time,
// using a valid/ready handshake with the coin ejector. When the remaining
// amount is below the smallest coin, a one-cycle o_done pulse is raised and
// the undispensable remainder is reported on o_residual.
// Optional feature: define CHANGE_COUNT_EN to add the o_coin_count output,
// an 8-bit saturating count of the coins dispensed in the current request.
// Data width: `kTotalBits (defaults to 16 if not defined elsewhere).

`ifndef kTotalBits
`define kTotalBits 16
`endif

module change_dispenser #(
    parameter int COIN_VAL_0 = 100,
    parameter int COIN_VAL_1 = 500,
    parameter int COIN_VAL_2 = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic [`kTotalBits-1:0] current_total,
    input  logic                   i_coin_ready,
    output logic                   o_coin_valid,
    output logic [2:0]             o_coin_type,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [`kTotalBits-1:0] o_residual
`ifdef CHANGE_COUNT_EN
    ,
    output logic [7:0]             o_coin_count
`endif
);

    localparam int TW = `kTotalBits;
    localparam logic [TW-1:0] COIN0_W = TW'(COIN_VAL_0);
    localparam logic [TW-1:0] COIN1_W = TW'(COIN_VAL_1);
    localparam logic [TW-1:0] COIN2_W = TW'(COIN_VAL_2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    // Largest coin not exceeding the remaining amount, as a one-hot select.
    // Returns zero when even the smallest coin does not fit.
    function automatic logic [2:0] select_coin(input logic [TW-1:0] rem);
        logic [2:0] sel;
        if (rem >= COIN2_W) begin
            sel = 3'b100;
        end else if (rem >= COIN1_W) begin
            sel = 3'b010;
        end else if (rem >= COIN0_W) begin
            sel = 3'b001;
        end else begin
            sel = 3'b000;
        end
        return sel;
    endfunction

    // Face value of a one-hot coin select.
    function automatic logic [TW-1:0] coin_value(input logic [2:0] sel);
        logic [TW-1:0] val;
        case (sel)
            3'b001:  val = COIN0_W;
            3'b010:  val = COIN1_W;
            3'b100:  val = COIN2_W;
            default: val = {TW{1'b0}};
        endcase
        return val;
    endfunction

    state_t          state_q, state_d;
    logic [TW-1:0]   remaining_q, remaining_d;
    logic            coin_valid_q, coin_valid_d;
    logic [2:0]      coin_type_q, coin_type_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [TW-1:0]   residual_q, residual_d;
    logic            handshake_s;
`ifdef CHANGE_COUNT_EN
    logic [7:0]      count_q, count_d;
`endif

    assign handshake_s = coin_valid_q & i_coin_ready;

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave DISPENSE only when no coin is outstanding
    // and nothing dispensable remains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_DISPENSE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPENSE: begin
                if (!coin_valid_q && (remaining_q < COIN0_W)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DISPENSE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; every output is registered below.
    // A coin is withdrawn for one cycle after each handshake, so the next
    // selection is made from the already-updated remaining amount.
    always_comb begin
        remaining_d  = remaining_q;
        coin_valid_d = coin_valid_q;
        coin_type_d  = coin_type_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        residual_d   = residual_q;
`ifdef CHANGE_COUNT_EN
        count_d      = count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    remaining_d = current_total;
                    busy_d      = 1'b1;
`ifdef CHANGE_COUNT_EN
                    count_d     = 8'd0;
`endif
                end else begin
                    busy_d      = 1'b0;
                end
            end
            S_DISPENSE: begin
                if (coin_valid_q) begin
                    if (handshake_s) begin
                        remaining_d  = remaining_q - coin_value(coin_type_q);
                        coin_valid_d = 1'b0;
                        coin_type_d  = 3'b000;
`ifdef CHANGE_COUNT_EN
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end else begin
                            count_d = count_q;
                        end
`endif
                    end else begin
                        coin_valid_d = 1'b1;
                        coin_type_d  = coin_type_q;
                    end
                end else if (remaining_q >= COIN0_W) begin
                    coin_valid_d = 1'b1;
                    coin_type_d  = select_coin(remaining_q);
                end else begin
                    done_d       = 1'b1;
                    residual_d   = remaining_q;
                end
            end
            S_DONE: begin
                busy_d       = 1'b0;
                coin_valid_d = 1'b0;
                coin_type_d  = 3'b000;
            end
            default: begin
                busy_d       = 1'b0;
                coin_valid_d = 1'b0;
                coin_type_d  = 3'b000;
            end
        endcase
    end

    // Datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            remaining_q  <= {TW{1'b0}};
            coin_valid_q <= 1'b0;
            coin_type_q  <= 3'b000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            residual_q   <= {TW{1'b0}};
        end else begin
            remaining_q  <= remaining_d;
            coin_valid_q <= coin_valid_d;
            coin_type_q  <= coin_type_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            residual_q   <= residual_d;
        end
    end

`ifdef CHANGE_COUNT_EN
    // Dispensed-coin counter, held after completion until the next request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_coin_count = count_q;
`endif

    assign o_coin_valid = coin_valid_q;
    assign o_coin_type  = coin_type_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_residual   = residual_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed corner cases plus
// randomized requests, compared against a greedy coin-change model.

`ifndef kTotalBits
`define kTotalBits 16
`endif

module tb_change_dispenser;

    localparam int TW = `kTotalBits;
    localparam int C0 = 100;
    localparam int C1 = 500;
    localparam int C2 = 1000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_start;
    logic [TW-1:0] current_total;
    logic          i_coin_ready;
    logic          o_coin_valid;
    logic [2:0]    o_coin_type;
    logic          o_busy;
    logic          o_done;
    logic [TW-1:0] o_residual;
`ifdef CHANGE_COUNT_EN
    logic [7:0]    o_coin_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .COIN_VAL_0(C0),
        .COIN_VAL_1(C1),
        .COIN_VAL_2(C2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .current_total(current_total),
        .i_coin_ready (i_coin_ready),
        .o_coin_valid (o_coin_valid),
        .o_coin_type  (o_coin_type),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_residual   (o_residual)
`ifdef CHANGE_COUNT_EN
        ,
        .o_coin_count (o_coin_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot_of(input int v);
        if (v == C2) return 3'b100;
        if (v == C1) return 3'b010;
        if (v == C0) return 3'b001;
        return 3'b000;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(o_coin_valid), 32'd0);
        check_eq({tag, "_type"},  32'(o_coin_type),  32'd0);
        check_eq({tag, "_busy"},  32'(o_busy),       32'd0);
        check_eq({tag, "_done"},  32'(o_done),       32'd0);
        check_eq({tag, "_resid"}, 32'(o_residual),   32'd0);
`ifdef CHANGE_COUNT_EN
        check_eq({tag, "_count"}, 32'(o_coin_count), 32'd0);
`endif
    endtask

    // One change request. stall_pct: chance of ready low per cycle;
    // stall_first: ready forced low for the first N cycles a coin is shown;
    // noise: toggle i_start/current_total while busy;
    // abort_after: apply reset right after this many coins (-1 = never).
    task automatic run_txn(input int total, input int stall_pct, input int stall_first,
                           input bit noise, input int abort_after);
        int   exp_q[$];
        int   rem;
        int   n_exp;
        int   coins;
        int   cycles;
        int   stalls_left;
        int   v;
        bit   done_seen;
        bit   aborted;
        bit   hold_prev;
        bit   rdy;
        logic [2:0] prev_type;

        // Reference: greedy change with plain arithmetic.
        rem = total;
        while (rem >= C0) begin
            if (rem >= C2)      begin exp_q.push_back(C2); rem -= C2; end
            else if (rem >= C1) begin exp_q.push_back(C1); rem -= C1; end
            else                begin exp_q.push_back(C0); rem -= C0; end
        end
        n_exp = exp_q.size();

        @(negedge clk);
        i_start       = 1'b1;
        current_total = TW'(total);
        i_coin_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        i_start = 1'b0;

        coins = 0; cycles = 1; stalls_left = stall_first;
        done_seen = 1'b0; aborted = 1'b0; hold_prev = 1'b0; prev_type = 3'b000;
        while (!done_seen && !aborted && cycles < 400) begin
            check_eq("busy", 32'(o_busy), 32'd1);
            if (hold_prev) begin
                check_eq("hold_valid", 32'(o_coin_valid), 32'd1);
                check_eq("hold_type",  32'(o_coin_type),  32'(prev_type));
            end
            hold_prev = 1'b0;
            if (o_done) begin
                done_seen = 1'b1;
                check_eq("done_valid", 32'(o_coin_valid), 32'd0);
                check_eq("coin_total", 32'(coins), 32'(n_exp));
                check_eq("residual",   32'(o_residual), 32'(rem));
`ifdef CHANGE_COUNT_EN
                check_eq("coin_count", 32'(o_coin_count), 32'(n_exp > 255 ? 255 : n_exp));
`endif
                if (stall_pct == 0 && stall_first == 0)
                    check_eq("done_latency", 32'(cycles), 32'(2 * n_exp + 2));
                i_start      = 1'b0;
                i_coin_ready = 1'b0;
            end else begin
                if (o_coin_valid && stalls_left > 0) begin
                    rdy = 1'b0;
                    stalls_left--;
                end else begin
                    rdy = ($urandom_range(0, 99) >= stall_pct);
                end
                i_coin_ready = rdy;
                if (noise) begin
                    i_start       = 1'($urandom_range(0, 1));
                    current_total = TW'($urandom);
                end
                if (o_coin_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_coin", 32'd1, 32'd0);
                    end else begin
                        v = exp_q.pop_front();
                        check_eq("coin_type", 32'(o_coin_type), 32'(onehot_of(v)));
                    end
                    coins++;
                    if (coins == abort_after) aborted = 1'b1;
                end else if (o_coin_valid) begin
                    hold_prev = 1'b1;
                    prev_type = o_coin_type;
                end
                @(negedge clk);
                cycles++;
            end
        end

        if (aborted) begin
            reset_n      = 1'b0;
            i_start      = 1'b0;
            i_coin_ready = 1'b0;
            @(negedge clk);
            check_all_zero("abort");
            reset_n = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check_eq("abort_no_done",  32'(o_done),       32'd0);
                check_eq("abort_no_valid", 32'(o_coin_valid), 32'd0);
                check_eq("abort_no_busy",  32'(o_busy),       32'd0);
            end
        end else begin
            check_eq("done_seen", 32'(done_seen), 32'd1);
            @(negedge clk);
            check_eq("done_pulse", 32'(o_done), 32'd0);
            check_eq("idle_busy",  32'(o_busy), 32'd0);
            check_eq("resid_hold", 32'(o_residual), 32'(rem));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        i_start       = 1'b1;
        i_coin_ready  = 1'b1;
        current_total = TW'(1600);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        i_start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_busy", 32'(o_busy), 32'd0);

        run_txn(1600, 0, 0, 1'b0, -1);
        run_txn(250,  0, 0, 1'b0, -1);
        run_txn(0,    0, 0, 1'b0, -1);
        run_txn(500,  0, 5, 1'b0, -1);
        run_txn(2000, 0, 0, 1'b1, -1);
        run_txn(1500, 0, 0, 1'b0, 1);
        run_txn(250,  0, 0, 1'b0, -1);

        for (int k = 0; k < 25; k++) begin
            run_txn(int'($urandom_range(0, 4000)), int'($urandom_range(0, 60)),
                    int'($urandom_range(0, 3)), 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
